// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM1 load/store stage: RISC-V funct3 size/sign codes,
// the access FSM state encoding and byte-mask helpers.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } lsu_state_e;

    // Byte-enable pattern for an access of 1/2/4/8 bytes (size code 0..3).
    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        logic [7:0] m;
        case (sz)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            2'd3:    m = 8'hFF;
            default: m = 8'h01;
        endcase
        return m;
    endfunction

    function automatic logic [2:0] size_m1(input logic [1:0] sz);
        logic [2:0] r;
        case (sz)
            2'd0:    r = 3'd0;
            2'd1:    r = 3'd1;
            2'd2:    r = 3'd3;
            2'd3:    r = 3'd7;
            default: r = 3'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem1_lsu_stage_load_align.sv
// Load data aligner: shifts the addressed bytes of an SRAM word down to bit 0 and
// sign- or zero-extends them to XLEN according to funct3.
module lsu_load_align #(
    parameter int XLEN   = 64,
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0]              rdata_i,
    input  logic [$clog2(DATA_W/8)-1:0]    offset_i,
    input  logic [2:0]                     funct3_i,
    output logic [XLEN-1:0]                value_o
);
    import lsu_pkg::*;

    logic [XLEN-1:0] sh_s;

    assign sh_s = XLEN'(rdata_i >> {offset_i, 3'b000});

    // Size/sign selection; a doubleword on a 32-bit core degenerates to the full word.
    always_comb begin
        value_o = '0;
        case (funct3_i)
            F3_LB:   value_o = XLEN'($signed(sh_s[7:0]));
            F3_LBU:  value_o = XLEN'(sh_s[7:0]);
            F3_LH:   value_o = XLEN'($signed(sh_s[15:0]));
            F3_LHU:  value_o = XLEN'(sh_s[15:0]);
            F3_LW:   value_o = XLEN'($signed(sh_s[31:0]));
            F3_LWU:  value_o = XLEN'(sh_s[31:0]);
            F3_LD:   value_o = sh_s;
            default: value_o = '0;
        endcase
    end

endmodule

// File: rtl/mem1_lsu_stage.sv
// MEM1 stage: registers the EX op, runs the req/gnt/rvalid SRAM handshake and feeds MEM2.
// Optional build macro MISALIGN_TRAP_EN turns misaligned accesses into an out_excp result.
module mem1_lsu_stage #(
    parameter int XLEN   = 64,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32,
    parameter int REG_AW = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  stall_in,
    output logic                  stall_req,
    input  logic                  in_valid,
    input  logic                  in_is_load,
    input  logic                  in_is_store,
    input  logic [2:0]            in_funct3,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [XLEN-1:0]       in_wdata,
    input  logic [REG_AW-1:0]     in_rd,
    input  logic                  in_rd_we,
    output logic                  sram_req,
    output logic                  sram_we,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W/8-1:0]   sram_wstrb,
    output logic [DATA_W-1:0]     sram_wdata,
    input  logic                  sram_gnt,
    input  logic                  sram_rvalid,
    input  logic [DATA_W-1:0]     sram_rdata,
    output logic                  out_valid,
    output logic [REG_AW-1:0]     out_rd,
    output logic                  out_rd_we,
    output logic [XLEN-1:0]       out_wdata,
    output logic                  out_excp
);
    import lsu_pkg::*;

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    lsu_state_e          state_q;
    logic                kill_q;
    logic [2:0]          f3_q;
    logic [OFF_W-1:0]    off_q;
    logic [REG_AW-1:0]   rd_q;
    logic                rd_we_q;
    logic                sram_req_q, sram_we_q;
    logic [ADDR_W-1:0]   sram_addr_q;
    logic [STRB_W-1:0]   sram_wstrb_q;
    logic [DATA_W-1:0]   sram_wdata_q;
    logic                out_valid_q, out_rd_we_q, out_excp_q;
    logic [REG_AW-1:0]   out_rd_q;
    logic [XLEN-1:0]     out_wdata_q;
    logic                hold_full_q, hold_rd_we_q, hold_excp_q;
    logic [REG_AW-1:0]   hold_rd_q;
    logic [XLEN-1:0]     hold_wdata_q;

    logic [1:0]          st_sz_s, ld_sz_s, sz_s;
    logic [OFF_W-1:0]    off_raw_s, off_al_s, m1_s;
    logic [STRB_W-1:0]   wstrb_s;
    logic [DATA_W-1:0]   wdata_rep_s;
    logic [63:0]         wd64_s;
    logic [ADDR_W-1:0]   addr_al_s;
    logic [XLEN-1:0]     ld_val_s;
    logic                is_mem_s, misal_s, accept_s, start_mem_s;
    logic                comp_valid_s, comp_rd_we_s, comp_excp_s;
    logic [REG_AW-1:0]   comp_rd_s;
    logic [XLEN-1:0]     comp_wdata_s;

    // Access size from funct3; doublewords shrink to words on a 32-bit core.
    always_comb begin
        st_sz_s = 2'd0;
        ld_sz_s = 2'd0;
        case (in_funct3)
            F3_SB:   st_sz_s = 2'd0;
            F3_SH:   st_sz_s = 2'd1;
            F3_SW:   st_sz_s = 2'd2;
            F3_SD:   st_sz_s = (XLEN == 32) ? 2'd2 : 2'd3;
            default: st_sz_s = 2'd0;
        endcase
        case (in_funct3)
            F3_LB, F3_LBU: ld_sz_s = 2'd0;
            F3_LH, F3_LHU: ld_sz_s = 2'd1;
            F3_LW, F3_LWU: ld_sz_s = 2'd2;
            F3_LD:         ld_sz_s = (XLEN == 32) ? 2'd2 : 2'd3;
            default:       ld_sz_s = 2'd0;
        endcase
    end

    assign sz_s      = in_is_store ? st_sz_s : ld_sz_s;
    assign is_mem_s  = in_is_load | in_is_store;
    assign off_raw_s = in_addr[OFF_W-1:0];
    assign m1_s      = OFF_W'(size_m1(sz_s));
    assign addr_al_s = {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

`ifdef MISALIGN_TRAP_EN
    assign misal_s  = is_mem_s & (|(off_raw_s & m1_s));
    assign off_al_s = off_raw_s;
`else
    assign misal_s  = 1'b0;
    assign off_al_s = off_raw_s & ~m1_s;
`endif

    assign wstrb_s = STRB_W'(size_mask(sz_s)) << off_al_s;
    assign wd64_s  = 64'(in_wdata);

    // Replicate the low store bytes across every lane of the SRAM word.
    always_comb begin
        wdata_rep_s = '0;
        for (int i = 0; i < STRB_W; i++) begin
            wdata_rep_s[8*i +: 8] = wd64_s[8*(i & int'(size_m1(st_sz_s))) +: 8];
        end
    end

    assign accept_s    = (state_q == ST_IDLE) & in_valid & ~stall_in & ~flush & ~hold_full_q;
    assign start_mem_s = accept_s & is_mem_s & ~misal_s;
    assign stall_req   = start_mem_s | (state_q != ST_IDLE) | hold_full_q;

    lsu_load_align #(
        .XLEN   (XLEN),
        .DATA_W (DATA_W)
    ) u_align (
        .rdata_i  (sram_rdata),
        .offset_i (off_q),
        .funct3_i (f3_q),
        .value_o  (ld_val_s)
    );

    // Result produced this cycle, if any; killed accesses finish on the bus but report nothing.
    always_comb begin
        comp_valid_s = 1'b0;
        comp_rd_s    = '0;
        comp_rd_we_s = 1'b0;
        comp_wdata_s = '0;
        comp_excp_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && !is_mem_s) begin
                    comp_valid_s = 1'b1;
                    comp_rd_s    = in_rd;
                    comp_rd_we_s = in_rd_we;
                    comp_wdata_s = in_wdata;
                end else if (accept_s && misal_s) begin
                    comp_valid_s = 1'b1;
                    comp_rd_s    = in_rd;
                    comp_excp_s  = 1'b1;
                end else begin
                    comp_valid_s = 1'b0;
                end
            end
            ST_REQ: begin
                if (sram_gnt && sram_we_q) begin
                    comp_valid_s = ~(kill_q | flush);
                    comp_rd_s    = rd_q;
                end else begin
                    comp_valid_s = 1'b0;
                end
            end
            ST_WAIT: begin
                if (sram_rvalid) begin
                    comp_valid_s = ~(kill_q | flush);
                    comp_rd_s    = rd_q;
                    comp_rd_we_s = rd_we_q;
                    comp_wdata_s = ld_val_s;
                end else begin
                    comp_valid_s = 1'b0;
                end
            end
            default: comp_valid_s = 1'b0;
        endcase
    end

    // Access FSM; request fields are frozen from issue until the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            kill_q       <= 1'b0;
            f3_q         <= 3'd0;
            off_q        <= '0;
            rd_q         <= '0;
            rd_we_q      <= 1'b0;
            sram_req_q   <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wstrb_q <= '0;
            sram_wdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_mem_s) begin
                        state_q      <= ST_REQ;
                        kill_q       <= 1'b0;
                        f3_q         <= in_funct3;
                        off_q        <= off_al_s;
                        rd_q         <= in_rd;
                        rd_we_q      <= in_rd_we;
                        sram_req_q   <= 1'b1;
                        sram_we_q    <= in_is_store;
                        sram_addr_q  <= addr_al_s;
                        sram_wstrb_q <= in_is_store ? wstrb_s : '0;
                        sram_wdata_q <= in_is_store ? wdata_rep_s : '0;
                    end
                end
                ST_REQ: begin
                    if (flush) kill_q <= 1'b1;
                    if (sram_gnt) begin
                        state_q      <= sram_we_q ? ST_IDLE : ST_WAIT;
                        sram_req_q   <= 1'b0;
                        sram_we_q    <= 1'b0;
                        sram_addr_q  <= '0;
                        sram_wstrb_q <= '0;
                        sram_wdata_q <= '0;
                    end
                end
                ST_WAIT: begin
                    if (flush) kill_q <= 1'b1;
                    if (sram_rvalid) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // MEM2 output register with a one-entry hold buffer for results finishing under stall_in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_rd_q     <= '0;
            out_rd_we_q  <= 1'b0;
            out_wdata_q  <= '0;
            out_excp_q   <= 1'b0;
            hold_full_q  <= 1'b0;
            hold_rd_q    <= '0;
            hold_rd_we_q <= 1'b0;
            hold_wdata_q <= '0;
            hold_excp_q  <= 1'b0;
        end else if (!stall_in) begin
            if (hold_full_q) begin
                out_valid_q <= 1'b1;
                out_rd_q    <= hold_rd_q;
                out_rd_we_q <= hold_rd_we_q;
                out_wdata_q <= hold_wdata_q;
                out_excp_q  <= hold_excp_q;
                hold_full_q <= 1'b0;
            end else begin
                out_valid_q <= comp_valid_s;
                out_rd_q    <= comp_rd_s;
                out_rd_we_q <= comp_rd_we_s;
                out_wdata_q <= comp_wdata_s;
                out_excp_q  <= comp_excp_s;
            end
        end else if (comp_valid_s) begin
            hold_full_q  <= 1'b1;
            hold_rd_q    <= comp_rd_s;
            hold_rd_we_q <= comp_rd_we_s;
            hold_wdata_q <= comp_wdata_s;
            hold_excp_q  <= comp_excp_s;
        end
    end

    assign sram_req   = sram_req_q;
    assign sram_we    = sram_we_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wstrb = sram_wstrb_q;
    assign sram_wdata = sram_wdata_q;
    assign out_valid  = out_valid_q;
    assign out_rd     = out_rd_q;
    assign out_rd_we  = out_rd_we_q;
    assign out_wdata  = out_wdata_q;
    assign out_excp   = out_excp_q;

endmodule

// File: tb/tb_mem1_lsu_stage.sv
// Directed bench for mem1_lsu_stage (default 64-bit configuration), hand-computed expectations.
module tb_mem1_lsu_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, stall_in, stall_req;
    logic        in_valid, in_is_load, in_is_store, in_rd_we;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [63:0] in_wdata;
    logic [4:0]  in_rd;
    logic        sram_req, sram_we, sram_gnt, sram_rvalid;
    logic [31:0] sram_addr;
    logic [7:0]  sram_wstrb;
    logic [63:0] sram_wdata, sram_rdata;
    logic        out_valid, out_rd_we, out_excp;
    logic [4:0]  out_rd;
    logic [63:0] out_wdata;

    int total = 0;
    int bad   = 0;

    localparam logic [63:0] RD0 = 64'h89AB_CDEF_0123_4567;

    always #5 clk = ~clk;

    mem1_lsu_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .stall_in    (stall_in),
        .stall_req   (stall_req),
        .in_valid    (in_valid),
        .in_is_load  (in_is_load),
        .in_is_store (in_is_store),
        .in_funct3   (in_funct3),
        .in_addr     (in_addr),
        .in_wdata    (in_wdata),
        .in_rd       (in_rd),
        .in_rd_we    (in_rd_we),
        .sram_req    (sram_req),
        .sram_we     (sram_we),
        .sram_addr   (sram_addr),
        .sram_wstrb  (sram_wstrb),
        .sram_wdata  (sram_wdata),
        .sram_gnt    (sram_gnt),
        .sram_rvalid (sram_rvalid),
        .sram_rdata  (sram_rdata),
        .out_valid   (out_valid),
        .out_rd      (out_rd),
        .out_rd_we   (out_rd_we),
        .out_wdata   (out_wdata),
        .out_excp    (out_excp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [63:0] wd,
                         input logic [4:0] rd, input logic we);
        in_valid    = 1'b1;
        in_is_load  = ld;
        in_is_store = st;
        in_funct3   = f3;
        in_addr     = addr;
        in_wdata    = wd;
        in_rd       = rd;
        in_rd_we    = we;
    endtask

    task automatic idle();
        in_valid    = 1'b0;
        in_is_load  = 1'b0;
        in_is_store = 1'b0;
    endtask

    // Load with immediate grant and rvalid one cycle later: result visible at T+3.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [4:0] rd, input logic [63:0] rdata, input logic [63:0] exp);
        drive(1'b1, 1'b0, f3, addr, 64'd0, rd, 1'b1);
        #1 chk({tag, "_stall_T"}, 64'(stall_req), 64'd1);
        tick();
        idle();
        chk({tag, "_req"}, 64'(sram_req), 64'd1);
        chk({tag, "_addr"}, 64'(sram_addr), 64'(addr & 32'hFFFF_FFF8));
        sram_gnt = 1'b1;
        tick();
        sram_gnt    = 1'b0;
        chk({tag, "_req_drop"}, 64'(sram_req), 64'd0);
        chk({tag, "_early"}, 64'(out_valid), 64'd0);
        sram_rvalid = 1'b1;
        sram_rdata  = rdata;
        tick();
        sram_rvalid = 1'b0;
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"}, out_wdata, exp);
        chk({tag, "_rd"}, 64'(out_rd), 64'(rd));
        chk({tag, "_we"}, 64'(out_rd_we), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; stall_in = 1'b0;
        in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0; in_rd_we = 1'b0;
        in_funct3 = 3'd0; in_addr = 32'd0; in_wdata = 64'd0; in_rd = 5'd0;
        sram_gnt = 1'b0; sram_rvalid = 1'b0; sram_rdata = 64'd0;
        tick();
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sram_req", 64'(sram_req), 64'd0);
        chk("rst_stall", 64'(stall_req), 64'd0);
        chk("rst_wdata", out_wdata, 64'd0);
        rst_n = 1'b1;
        tick();

        // Non-memory op: latency 1, no stall
        drive(1'b0, 1'b0, 3'd0, 32'h0, 64'h1234_5678_9ABC_DEF0, 5'd5, 1'b1);
        #1 chk("alu_stall", 64'(stall_req), 64'd0);
        tick();
        idle();
        chk("alu_valid", 64'(out_valid), 64'd1);
        chk("alu_rd", 64'(out_rd), 64'd5);
        chk("alu_data", out_wdata, 64'h1234_5678_9ABC_DEF0);
        chk("alu_sram", 64'(sram_req), 64'd0);
        tick();
        chk("alu_pulse", 64'(out_valid), 64'd0);

        do_load("lw",  3'b010, 32'h104, 5'd7, RD0, 64'hFFFF_FFFF_89AB_CDEF);
        do_load("lbu", 3'b100, 32'h107, 5'd8, RD0, 64'h0000_0000_0000_0089);
        do_load("lb",  3'b000, 32'h107, 5'd8, RD0, 64'hFFFF_FFFF_FFFF_FF89);
        do_load("lhu", 3'b101, 32'h102, 5'd2, RD0, 64'h0000_0000_0000_0123);
        do_load("ld",  3'b011, 32'h100, 5'd3, RD0, RD0);
`ifdef MISALIGN_TRAP_EN
        drive(1'b1, 1'b0, 3'b010, 32'h102, 64'd0, 5'd4, 1'b1);
        tick();
        idle();
        chk("mis_req", 64'(sram_req), 64'd0);
        chk("mis_valid", 64'(out_valid), 64'd1);
        chk("mis_excp", 64'(out_excp), 64'd1);
        chk("mis_we", 64'(out_rd_we), 64'd0);
`else
        do_load("lw_trunc", 3'b010, 32'h106, 5'd4, RD0, 64'hFFFF_FFFF_89AB_CDEF);
        chk("excp_tied", 64'(out_excp), 64'd0);
`endif
        tick();

        // Store halfword: lane replication and strobes
        drive(1'b0, 1'b1, 3'b001, 32'h10A, 64'h0000_0000_0000_BEEF, 5'd3, 1'b1);
        #1 chk("sh_stall_T", 64'(stall_req), 64'd1);
        tick();
        idle();
        chk("sh_req", 64'(sram_req), 64'd1);
        chk("sh_we", 64'(sram_we), 64'd1);
        chk("sh_addr", 64'(sram_addr), 64'h108);
        chk("sh_wstrb", 64'(sram_wstrb), 64'h0C);
        chk("sh_wdata", sram_wdata, 64'hBEEF_BEEF_BEEF_BEEF);
        sram_gnt = 1'b1;
        tick();
        sram_gnt = 1'b0;
        chk("sh_valid", 64'(out_valid), 64'd1);
        chk("sh_rd_we", 64'(out_rd_we), 64'd0);
        chk("sh_stall_end", 64'(stall_req), 64'd0);
        tick();

        // Grant delayed: request fields stable, single output pulse
        drive(1'b1, 1'b0, 3'b010, 32'h110, 64'd0, 5'd9, 1'b1);
        tick();
        idle();
        for (int k = 0; k < 4; k++) begin
            chk("dly_req", 64'(sram_req), 64'd1);
            chk("dly_addr", 64'(sram_addr), 64'h110);
            chk("dly_stall", 64'(stall_req), 64'd1);
            chk("dly_noout", 64'(out_valid), 64'd0);
            if (k == 3) sram_gnt = 1'b1;
            tick();
        end
        sram_gnt    = 1'b0;
        chk("dly_req_drop", 64'(sram_req), 64'd0);
        sram_rvalid = 1'b1;
        sram_rdata  = 64'h0000_0000_7FFF_0000;
        tick();
        sram_rvalid = 1'b0;
        chk("dly_valid", 64'(out_valid), 64'd1);
        chk("dly_data", out_wdata, 64'h0000_0000_7FFF_0000);
        tick();
        chk("dly_pulse", 64'(out_valid), 64'd0);

        // Flush while waiting for read data: result discarded
        drive(1'b1, 1'b0, 3'b011, 32'h120, 64'd0, 5'd10, 1'b1);
        tick();
        idle();
        sram_gnt = 1'b1;
        tick();
        sram_gnt = 1'b0;
        flush    = 1'b1;
        #1 chk("fl_stall_wait", 64'(stall_req), 64'd1);
        tick();
        flush       = 1'b0;
        sram_rvalid = 1'b1;
        sram_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        sram_rvalid = 1'b0;
        chk("fl_dropped", 64'(out_valid), 64'd0);
        chk("fl_idle", 64'(stall_req), 64'd0);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 64'h55, 5'd12, 1'b1);
        tick();
        idle();
        chk("fl_next_valid", 64'(out_valid), 64'd1);
        chk("fl_next_data", out_wdata, 64'h55);

        // Flush in IDLE on the accept cycle drops the op
        drive(1'b1, 1'b0, 3'b010, 32'h130, 64'd0, 5'd1, 1'b1);
        flush = 1'b1;
        #1 chk("fli_stall", 64'(stall_req), 64'd0);
        tick();
        idle();
        flush = 1'b0;
        chk("fli_req", 64'(sram_req), 64'd0);
        chk("fli_valid", 64'(out_valid), 64'd0);

        // Downstream stall: completed load parks in the hold register
        drive(1'b1, 1'b0, 3'b100, 32'h101, 64'd0, 5'd11, 1'b1);
        tick();
        idle();
        sram_gnt = 1'b1;
        stall_in = 1'b1;
        tick();
        sram_gnt    = 1'b0;
        sram_rvalid = 1'b1;
        sram_rdata  = RD0;
        tick();
        sram_rvalid = 1'b0;
        chk("st_held", 64'(out_valid), 64'd0);
        chk("st_hold_req", 64'(stall_req), 64'd1);
        tick();
        chk("st_held2", 64'(out_valid), 64'd0);
        stall_in = 1'b0;
        tick();
        chk("st_release", 64'(out_valid), 64'd1);
        chk("st_data", out_wdata, 64'h45);
        chk("st_rd", 64'(out_rd), 64'd11);
        chk("st_free", 64'(stall_req), 64'd0);
        tick();
        chk("st_pulse", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
